// File: rtl/traffic_monitor_if.sv
// ---------------------------------------------------------------------------
// traffic_monitor_if
//
// Purpose: bundles the timebase/acknowledge strobes, the ten lamp drives and
//          the monitor status outputs of traffic_monitor into one interface.
//
// Signals:
//   tick        timebase strobe, one cycle wide
//   clear       fault acknowledge
//   T12R/Y/G    three-aspect head 1+2 lamp drives
//   T34R/Y/G    three-aspect head 3+4 lamp drives
//   T5R/G       two-aspect head 5 lamp drives
//   T6R/G       two-aspect head 6 lamp drives
//   fault       latched fault flag
//   fault_code  cause of latched fault (0 = none)
//   flash       flasher relay drive, toggles per tick in FAULT
//   mon_state   0 = ARM, 1 = MONITOR, 2 = FAULT
//
// Modports:
//   master  drives strobes and lamps, observes status (controller / bench)
//   slave   the monitor itself
// ---------------------------------------------------------------------------
interface traffic_monitor_if;
  logic       tick;
  logic       clear;
  logic       T12R, T12Y, T12G;
  logic       T34R, T34Y, T34G;
  logic       T5R, T5G;
  logic       T6R, T6G;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash;
  logic [1:0] mon_state;

  modport master (
    output tick, clear,
    output T12R, T12Y, T12G, T34R, T34Y, T34G, T5R, T5G, T6R, T6G,
    input  fault, fault_code, flash, mon_state
  );

  modport slave (
    input  tick, clear,
    input  T12R, T12Y, T12G, T34R, T34Y, T34G, T5R, T5G, T6R, T6G,
    output fault, fault_code, flash, mon_state
  );
endinterface

// File: rtl/traffic_monitor.sv
// ---------------------------------------------------------------------------
// traffic_monitor
//
// Purpose: independent conflict monitor on the lamp side of the intersection
//          controller. On every timebase tick it checks head validity,
//          conflicting greens, aspect sequence, minimum yellow, minimum
//          all-red clearance and (optionally) maximum green. The first
//          violation latches a fault code and starts toggling the flash
//          output for the external flasher relay until acknowledged.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   bus    slave modport of traffic_monitor_if (tick, clear, ten lamp
//               drives in; fault, fault_code, flash, mon_state out)
//
// Parameters:
//   MIN_YELLOW     minimum ticks a yellow is held before red
//   MIN_RED_CLEAR  minimum all-red ticks before any head turns green
//   MAX_GREEN      maximum ticks a three-aspect green may be held
//   CNT_W          width of the saturating duration counters
//
// Configuration macro:
//   TMON_MAXGREEN_EN  when defined, green duration counters and the
//                     stuck-green check (code 6) are built in.
// ---------------------------------------------------------------------------
module traffic_monitor #(
  parameter int MIN_YELLOW    = 4,
  parameter int MIN_RED_CLEAR = 4,
  parameter int MAX_GREEN     = 30,
  parameter int CNT_W         = 8
) (
  input logic              clk,
  input logic              reset,
  traffic_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    ARM     = 2'd0,
    MONITOR = 2'd1,
    FAULT   = 2'd2
  } state_t;

  typedef struct packed {
    logic t12R, t12Y, t12G;
    logic t34R, t34Y, t34G;
    logic t5R, t5G;
    logic t6R, t6G;
  } lamps_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state, w_nextState;
  lamps_t           r_prev;
  logic [CNT_W-1:0] r_yelCnt12, r_yelCnt34, r_allRedCnt;
  logic             r_fault, r_flash;
  logic [2:0]       r_faultCode;

  lamps_t           w_cur;
  logic [CNT_W-1:0] w_yelNext12, w_yelNext34, w_allRedNext;
  logic             w_allRed, w_invalid, w_conflict, w_seqErr;
  logic             w_shortYel, w_shortClr, w_stuck, w_enterG;
  logic             w_x12, w_x34;
  logic [2:0]       w_code;

  // Zero when the aspect is off, restart at 1 on entry, otherwise saturate up.
  function automatic logic [CNT_W-1:0] holdCount(input logic nowOn, input logic wasOn,
                                                 input logic [CNT_W-1:0] cnt);
    if (!nowOn) return '0;
    if (!wasOn) return CNT_ONE;
    return (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  endfunction

  assign w_cur = {bus.T12R, bus.T12Y, bus.T12G, bus.T34R, bus.T34Y, bus.T34G,
                  bus.T5R, bus.T5G, bus.T6R, bus.T6G};

  assign w_allRed = w_cur.t12R & w_cur.t34R & w_cur.t5R & w_cur.t6R;

  // Three inputs are "exactly one" when their parity is odd and not all three set.
  assign w_invalid = ~((w_cur.t12R ^ w_cur.t12Y ^ w_cur.t12G) & ~(w_cur.t12R & w_cur.t12Y & w_cur.t12G))
                   | ~((w_cur.t34R ^ w_cur.t34Y ^ w_cur.t34G) & ~(w_cur.t34R & w_cur.t34Y & w_cur.t34G))
                   | ~(w_cur.t5R ^ w_cur.t5G)
                   | ~(w_cur.t6R ^ w_cur.t6G);

  // A yellow still occupies the junction, so it conflicts just like green.
  assign w_x12      = w_cur.t12G | w_cur.t12Y;
  assign w_x34      = w_cur.t34G | w_cur.t34Y;
  assign w_conflict = (w_x12 & w_x34) | (w_x12 & w_cur.t5G) | (w_x34 & w_cur.t6G)
                    | (w_cur.t5G & w_cur.t6G);

  assign w_seqErr = (r_prev.t12G & w_cur.t12R) | (r_prev.t12R & w_cur.t12Y) | (r_prev.t12Y & w_cur.t12G)
                  | (r_prev.t34G & w_cur.t34R) | (r_prev.t34R & w_cur.t34Y) | (r_prev.t34Y & w_cur.t34G);

  assign w_yelNext12  = holdCount(w_cur.t12Y, r_prev.t12Y, r_yelCnt12);
  assign w_yelNext34  = holdCount(w_cur.t34Y, r_prev.t34Y, r_yelCnt34);
  assign w_allRedNext = holdCount(w_allRed, 1'b1, r_allRedCnt);

  // Stored yellow count already covers every yellow tick before this red one.
  assign w_shortYel = (r_prev.t12Y & w_cur.t12R & (int'(r_yelCnt12) < MIN_YELLOW))
                    | (r_prev.t34Y & w_cur.t34R & (int'(r_yelCnt34) < MIN_YELLOW));

  assign w_enterG   = (w_cur.t12G & ~r_prev.t12G) | (w_cur.t34G & ~r_prev.t34G)
                    | (w_cur.t5G & ~r_prev.t5G) | (w_cur.t6G & ~r_prev.t6G);
  assign w_shortClr = w_enterG & (int'(r_allRedCnt) < MIN_RED_CLEAR);

`ifdef TMON_MAXGREEN_EN
  logic [CNT_W-1:0] r_grnCnt12, r_grnCnt34;
  logic [CNT_W-1:0] w_grnNext12, w_grnNext34;

  assign w_grnNext12 = holdCount(w_cur.t12G, r_prev.t12G, r_grnCnt12);
  assign w_grnNext34 = holdCount(w_cur.t34G, r_prev.t34G, r_grnCnt34);
  // Judged on the count including this tick, so the fault lands on tick MAX_GREEN+1.
  assign w_stuck = (int'(w_grnNext12) > MAX_GREEN) | (int'(w_grnNext34) > MAX_GREEN);

  // Green duration counters follow the same arm/update rules as the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grnCnt12 <= '0;
      r_grnCnt34 <= '0;
    end else if (bus.tick && r_state == ARM && !w_invalid && !w_conflict) begin
      r_grnCnt12 <= '0;
      r_grnCnt34 <= '0;
    end else if (bus.tick && r_state == MONITOR && w_code == 3'd0) begin
      r_grnCnt12 <= w_grnNext12;
      r_grnCnt34 <= w_grnNext34;
    end
  end
`else
  assign w_stuck = 1'b0;
`endif

  // Lowest-numbered failing check wins.
  always_comb begin
    w_code = 3'd0;
    if (w_invalid)       w_code = 3'd1;
    else if (w_conflict) w_code = 3'd2;
    else if (w_seqErr)   w_code = 3'd3;
    else if (w_shortYel) w_code = 3'd4;
    else if (w_shortClr) w_code = 3'd5;
    else if (w_stuck)    w_code = 3'd6;
  end

  // Next-state logic; clear is the only input acted on without a tick.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ARM:     if (bus.tick && !w_invalid && !w_conflict) w_nextState = MONITOR;
      MONITOR: if (bus.tick && w_code != 3'd0)            w_nextState = FAULT;
      FAULT:   if (bus.clear)                             w_nextState = ARM;
      default: w_nextState = ARM;
    endcase
  end

  // State register plus history, counters and the registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ARM;
      r_prev      <= '0;
      r_yelCnt12  <= '0;
      r_yelCnt34  <= '0;
      r_allRedCnt <= '0;
      r_fault     <= 1'b0;
      r_faultCode <= 3'd0;
      r_flash     <= 1'b0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        ARM: begin
          if (bus.tick && !w_invalid && !w_conflict) begin
            r_prev      <= w_cur;
            r_yelCnt12  <= '0;
            r_yelCnt34  <= '0;
            r_allRedCnt <= '0;
          end
        end
        MONITOR: begin
          if (bus.tick) begin
            if (w_code != 3'd0) begin
              r_fault     <= 1'b1;
              r_faultCode <= w_code;
            end else begin
              r_prev      <= w_cur;
              r_yelCnt12  <= w_yelNext12;
              r_yelCnt34  <= w_yelNext34;
              r_allRedCnt <= w_allRedNext;
            end
          end
        end
        FAULT: begin
          if (bus.clear) begin
            r_fault     <= 1'b0;
            r_faultCode <= 3'd0;
            r_flash     <= 1'b0;
          end else if (bus.tick) begin
            r_flash <= ~r_flash;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fault      = r_fault;
  assign bus.fault_code = r_faultCode;
  assign bus.flash      = r_flash;
  assign bus.mon_state  = r_state;

endmodule

// File: tb/tb_traffic_monitor.sv
// ---------------------------------------------------------------------------
// tb_traffic_monitor
//
// Purpose: directed self-checking bench for traffic_monitor. Lamp patterns
//          are packed as {T12R,T12Y,T12G,T34R,T34Y,T34G,T5R,T5G,T6R,T6G}.
//          Define TMON_MAXGREEN_EN for both bench and design to exercise
//          the stuck-green check.
// ---------------------------------------------------------------------------
module tb_traffic_monitor;

  localparam logic [9:0] ALL_RED  = 10'b100_100_10_10;
  localparam logic [9:0] P12G     = 10'b001_100_10_01;
  localparam logic [9:0] P12Y     = 10'b010_100_10_01;
  localparam logic [9:0] P34G     = 10'b100_001_01_10;
  localparam logic [9:0] P34Y     = 10'b100_010_01_10;
  localparam logic [9:0] BOTH_G   = 10'b001_001_10_10;
  localparam logic [9:0] T12_RG   = 10'b101_100_10_10;

  logic clk;
  logic reset;
  int   vectorCount;
  int   missCount;

  traffic_monitor_if bus ();

  traffic_monitor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drives one cycle of stimulus at the falling edge, returns 1 ns after the rising edge.
  task automatic applyStimulus(input logic [9:0] lamps, input logic tk, input logic clr);
    @(negedge clk);
    reset = 1'b0;
    {bus.T12R, bus.T12Y, bus.T12G, bus.T34R, bus.T34Y, bus.T34G,
     bus.T5R, bus.T5G, bus.T6R, bus.T6G} = lamps;
    bus.tick  = tk;
    bus.clear = clr;
    @(posedge clk);
    #1;
  endtask

  // Reset with tick and a conflicting pattern present, so reset must dominate.
  task automatic resetDut();
    @(negedge clk);
    reset = 1'b1;
    {bus.T12R, bus.T12Y, bus.T12G, bus.T34R, bus.T34Y, bus.T34G,
     bus.T5R, bus.T5G, bus.T6R, bus.T6G} = BOTH_G;
    bus.tick  = 1'b1;
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_fault"}, 8'(bus.fault), 8'd0);
    checkOutput({tag, "_code"},  8'(bus.fault_code), 8'd0);
    checkOutput({tag, "_flash"}, 8'(bus.flash), 8'd0);
    checkOutput({tag, "_state"}, 8'(bus.mon_state), 8'd0);
  endtask

  // Holds a legal pattern for n ticks, expecting MONITOR and no fault each tick.
  task automatic holdLegal(input logic [9:0] lamps, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      applyStimulus(lamps, 1'b1, 1'b0);
      checkOutput({tag, "_fault"}, 8'(bus.fault), 8'd0);
      checkOutput({tag, "_state"}, 8'(bus.mon_state), 8'd1);
    end
  endtask

  // Arms from all-red, then accumulates the given number of all-red ticks.
  task automatic armAllRed(input int redTicks, input string tag);
    applyStimulus(ALL_RED, 1'b1, 1'b0);
    checkOutput({tag, "_armed"}, 8'(bus.mon_state), 8'd1);
    holdLegal(ALL_RED, redTicks, tag);
  endtask

  task automatic expectFault(input logic [2:0] code, input string tag);
    checkOutput({tag, "_fault"}, 8'(bus.fault), 8'd1);
    checkOutput({tag, "_code"},  8'(bus.fault_code), 8'(code));
    checkOutput({tag, "_state"}, 8'(bus.mon_state), 8'd2);
    checkOutput({tag, "_flash"}, 8'(bus.flash), 8'd0);
  endtask

  initial begin
    clk         = 1'b0;
    reset       = 1'b1;
    vectorCount = 0;
    missCount   = 0;
    bus.tick    = 1'b0;
    bus.clear   = 1'b0;
    {bus.T12R, bus.T12Y, bus.T12G, bus.T34R, bus.T34Y, bus.T34G,
     bus.T5R, bus.T5G, bus.T6R, bus.T6G} = ALL_RED;

    resetDut();
    checkIdle("reset");

    // No faults raised in ARM, even for an invalid/conflicting sample.
    applyStimulus(BOTH_G, 1'b1, 1'b0);
    checkIdle("armConflict");
    applyStimulus(T12_RG, 1'b1, 1'b0);
    checkIdle("armInvalid");

    // Legal cycle repeated three times.
    armAllRed(4, "legalArm");
    for (int c = 0; c < 3; c++) begin
      holdLegal(P12G, 10, "leg12G");
      holdLegal(P12Y, 4,  "leg12Y");
      holdLegal(ALL_RED, 4, "legRedA");
      holdLegal(P34G, 10, "leg34G");
      holdLegal(P34Y, 4,  "leg34Y");
      holdLegal(ALL_RED, 4, "legRedB");
    end

    // Conflicting greens, flash behaviour, then acknowledge.
    applyStimulus(BOTH_G, 1'b1, 1'b0);
    expectFault(3'd2, "conflict");
    applyStimulus(P12G, 1'b1, 1'b0);
    checkOutput("flashTick1", 8'(bus.flash), 8'd1);
    checkOutput("flashCodeHeld", 8'(bus.fault_code), 8'd2);
    applyStimulus(P12G, 1'b0, 1'b0);
    checkOutput("flashNoTick", 8'(bus.flash), 8'd1);
    applyStimulus(ALL_RED, 1'b1, 1'b0);
    checkOutput("flashTick2", 8'(bus.flash), 8'd0);
    applyStimulus(ALL_RED, 1'b1, 1'b0);
    checkOutput("flashTick3", 8'(bus.flash), 8'd1);
    applyStimulus(ALL_RED, 1'b1, 1'b1);
    checkIdle("clear");
    applyStimulus(ALL_RED, 1'b1, 1'b0);
    checkOutput("rearm_state", 8'(bus.mon_state), 8'd1);

    // Short yellow.
    resetDut();
    armAllRed(4, "syArm");
    holdLegal(P12G, 2, "sy12G");
    holdLegal(P12Y, 2, "sy12Y");
    applyStimulus(ALL_RED, 1'b1, 1'b0);
    expectFault(3'd4, "shortYellow");

    // Same stimulus but T12R and T12G together: invalid outranks short yellow.
    resetDut();
    armAllRed(4, "prArm");
    holdLegal(P12G, 2, "pr12G");
    holdLegal(P12Y, 2, "pr12Y");
    applyStimulus(T12_RG, 1'b1, 1'b0);
    expectFault(3'd1, "priority");

    // Green straight to red.
    resetDut();
    armAllRed(4, "sqArm");
    holdLegal(P12G, 2, "sq12G");
    applyStimulus(ALL_RED, 1'b1, 1'b0);
    expectFault(3'd3, "sequence");

    // Reset mid-FAULT, then insufficient all-red before a green.
    resetDut();
    checkIdle("resetFault");
    armAllRed(2, "clArm");
    applyStimulus(P34G, 1'b1, 1'b0);
    expectFault(3'd5, "clearance");

    // Green held for 31 ticks.
    resetDut();
    armAllRed(4, "sgArm");
    holdLegal(P12G, 30, "sg12G");
    applyStimulus(P12G, 1'b1, 1'b0);
`ifdef TMON_MAXGREEN_EN
    expectFault(3'd6, "stuckGreen");
`else
    checkOutput("noStuck_fault", 8'(bus.fault), 8'd0);
    checkOutput("noStuck_state", 8'(bus.mon_state), 8'd1);
`endif

    // Idle cycles in MONITOR change nothing, then reset mid-MONITOR.
    resetDut();
    armAllRed(2, "rmArm");
    applyStimulus(BOTH_G, 1'b0, 1'b0);
    checkOutput("noTick_fault", 8'(bus.fault), 8'd0);
    checkOutput("noTick_state", 8'(bus.mon_state), 8'd1);
    resetDut();
    checkIdle("resetMonitor");

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/traffic_monitor.md
# traffic_monitor

Independent conflict monitor on the light-output side of the intersection controller. Samples the ten lamp drives (T12R/Y/G, T34R/Y/G, T5R/G, T6R/G) on every timebase tick and checks head validity, conflicting greens, aspect sequence and minimum/maximum interval durations. On the first violation it latches a fault code and toggles a flash output for the external flasher relay.

## Interface
- MIN_YELLOW, 4: minimum ticks a yellow must be held before red.
- MIN_RED_CLEAR, 4: minimum all-red ticks between one approach leaving yellow and the other turning green.
- MAX_GREEN, 30: maximum ticks any green may be held (only with TMON_MAXGREEN_EN).
- CNT_W, 8: width of all duration counters.

- clk  in  1  system clock
- reset  in  1  synchronous, active-high; dominates all other inputs
- tick  in  1  one-cycle timebase strobe; all checks evaluated only on cycles with tick=1
- clear  in  1  fault acknowledge; honoured only in FAULT
- T12R, T12Y, T12G, T34R, T34Y, T34G  in  1 each  three-aspect vehicle heads
- T5R, T5G, T6R, T6G  in  1 each  two-aspect heads
- fault  out  1  latched fault flag
- fault_code  out  3  cause of latched fault, 0 = none
- flash  out  1  toggles each tick while in FAULT, else 0
- mon_state  out  2  0 = ARM, 1 = MONITOR, 2 = FAULT

## Operation
- FSM states ARM, MONITOR, FAULT.
- ARM: on tick, if all heads valid and no conflict, capture the sample as "previous", zero counters, go to MONITOR; otherwise stay in ARM. No faults raised in ARM.
- MONITOR: each tick, evaluate checks below against current sample and stored previous sample; if any fails go to FAULT, else update previous sample and counters.
- Fault codes, lowest number wins when several fail on the same tick:
  - 1 invalid head: T12 or T34 not exactly one of R/Y/G; T5 or T6 not exactly one of R/G.
  - 2 conflict: (T12 G|Y) with (T34 G|Y); (T12 G|Y) with T5G; (T34 G|Y) with T6G; T5G with T6G. T12/T6 and T34/T5 are compatible.
  - 3 sequence: per three-aspect head only G→Y, Y→R, R→G permitted (or hold); G→R or R→Y illegal.
  - 4 short yellow: Y→R with yellow count < MIN_YELLOW.
  - 5 short clearance: any head enters G while all-red count < MIN_RED_CLEAR.
  - 6 stuck green: any green count > MAX_GREEN.
- Counters: per three-aspect head a yellow count and green count (reset to 1 on entering the aspect, increment each tick while held); all-red count = ticks with T12R, T34R, T5R, T6R all high. All counters saturate at 2^CNT_W−1.
- FAULT: fault=1, fault_code held, flash toggles on each tick, inputs ignored. clear=1 → ARM, fault=0, fault_code=0, flash=0.

## Timing
- Reset values: fault=0, fault_code=0, flash=0, mon_state=0 (ARM), counters and previous sample 0.
- Outputs registered: violation sampled on tick cycle N appears on fault/fault_code at cycle N+1.
- flash first rises on the first tick after entering FAULT.
- clear and tick in the same cycle in FAULT: clear wins, no flash toggle.
- reset mid-FAULT or mid-MONITOR: all state returns to reset values on the next edge; history discarded.
- tick=0 cycles: no state, counter or output change (except clear in FAULT).

## Configuration
- TMON_MAXGREEN_EN defined: green counters and code 6 check present.
- Undefined: green counters removed, code 6 never produced, MAX_GREEN unused; all other behaviour identical.

## Test plan
- Legal cycle: T12G/T6G 10 ticks, T12Y 4, all-red 4, T34G/T5G 10, T34Y 4, all-red 4, repeated 3 times → fault=0, mon_state=1 throughout.
- Conflict: in MONITOR drive T12G=1 and T34G=1 on one tick → fault=1, fault_code=2 one cycle later; flash toggles on subsequent ticks.
- Short yellow: T12Y held 2 ticks then T12R → fault_code=4; same stimulus with both T12G and T12R high at once → fault_code=1 (priority).
- Sequence/clearance: T12G→T12R directly → code 3; all-red 2 ticks then T34G → code 5.
- Stuck green (with TMON_MAXGREEN_EN): T12G held 31 ticks → code 6 on tick 31; without macro → no fault.
- Recovery: in FAULT assert clear → mon_state=0, fault=0 next cycle; reset asserted mid-MONITOR → all outputs 0, mon_state=0.
